// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch / data / memory bus bundle shared by mem_arbiter and
//               its requesters.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_instr;
    logic              if_stall;
    // data side
    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;
    // memory side
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              busy;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_instr, if_stall,
        input  dm_req, dm_wr, dm_addr, dm_wdata,
        output dm_done, dm_rdata, dm_stall,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_done,
        output busy
    );

    // requester / memory-model view
    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_instr, if_stall,
        output dm_req, dm_wr, dm_addr, dm_wdata,
        input  dm_done, dm_rdata, dm_stall,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_done,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one variable-latency memory between instruction fetch
//               and data accesses; one access in flight, stale fetches killed.
//               Optional macro MEM_ARB_RR_EN selects round-robin arbitration
//               (default: fixed data-over-fetch priority).
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_owner_dm;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_killed;
    logic              r_if_done_q;
    logic              r_dm_done_q;
    logic [DATA_W-1:0] r_if_instr;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_if_elig;
    logic              w_dm_elig;
    logic              w_pick_dm;
    logic              w_grant;
    logic              w_complete;
    logic              w_kill;
    logic              w_mem_en;
    logic              w_mem_wr;
    logic              w_busy;

    // A requester still showing its done pulse is holding a stale request.
    assign w_if_elig = bus.if_req & ~r_if_done_q & ~bus.if_flush;
    assign w_dm_elig = bus.dm_req & ~r_dm_done_q;

`ifdef MEM_ARB_RR_EN
    // r_last_grant: 1 = data was granted last, 0 = fetch.
    logic r_last_grant;

    assign w_pick_dm = w_dm_elig & (~w_if_elig | ~r_last_grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b0;
        end else if (w_grant) begin
            r_last_grant <= w_pick_dm;
        end
    end
`else
    assign w_pick_dm = w_dm_elig;
`endif

    assign w_complete = (r_state == C_WAIT) & bus.mem_done;
    // A flush arriving in the completion cycle kills the fetch as well.
    assign w_kill     = r_killed | bus.if_flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (w_dm_elig || w_if_elig) begin
                    w_grant     = 1'b1;
                    w_state_nxt = C_ISSUE;
                end
            end
            C_ISSUE: begin
                w_state_nxt = C_WAIT;
            end
            C_WAIT: begin
                if (bus.mem_done) begin
                    w_state_nxt = C_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_en = 1'b0;
        w_mem_wr = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            C_ISSUE: begin
                w_mem_en = 1'b1;
                w_mem_wr = r_wr;
                w_busy   = 1'b1;
            end
            C_WAIT: begin
                w_mem_wr = r_wr;
                w_busy   = 1'b1;
            end
            default: begin
                w_mem_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched command
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_dm <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_grant) begin
            r_owner_dm <= w_pick_dm;
            r_wr       <= w_pick_dm & bus.dm_wr;
            r_addr     <= w_pick_dm ? bus.dm_addr  : bus.if_addr;
            r_wdata    <= w_pick_dm ? bus.dm_wdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Fetch kill flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_killed <= 1'b0;
        end else if (w_complete) begin
            r_killed <= 1'b0;
        end else if ((r_state != C_IDLE) && !r_owner_dm && bus.if_flush) begin
            r_killed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completion: done pulses and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_done_q <= 1'b0;
            r_dm_done_q <= 1'b0;
            r_if_instr  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_done_q <= w_complete & ~r_owner_dm & ~w_kill;
            r_dm_done_q <= w_complete & r_owner_dm;
            if (w_complete && !r_owner_dm && !w_kill) begin
                r_if_instr <= bus.mem_rdata;
            end
            // Writes complete with a done pulse but leave read data alone.
            if (w_complete && r_owner_dm && !r_wr) begin
                r_dm_rdata <= bus.mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.if_done   = r_if_done_q & ~bus.if_flush;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.dm_done   = r_dm_done_q;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed, table-driven self-checking bench for mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;      // cycles from mem_en to mem_done
        logic        exp_wr;
        logic [15:0] exp_out;  // owner's result register after completion
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [15:0] exp_if_instr;
    logic [15:0] exp_dm_rdata;
    logic        first_is_data;
    vec_t        vecs[6];
    vec_t        v_tmp;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.dm_req    = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_done  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        cyc;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk({tag, "_rst_mem_en"},   bus.mem_en, 0);
        chk({tag, "_rst_mem_wr"},   bus.mem_wr, 0);
        chk({tag, "_rst_busy"},     bus.busy, 0);
        chk({tag, "_rst_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_rst_wdata"},    bus.mem_wdata, 0);
        chk({tag, "_rst_if_instr"}, bus.if_instr, 0);
        chk({tag, "_rst_dm_rdata"}, bus.dm_rdata, 0);
        chk({tag, "_rst_dones"},    {bus.if_done, bus.dm_done}, 0);
        cyc;
        rst = 1'b1;
        exp_if_instr = '0;
        exp_dm_rdata = '0;
    endtask

    // One isolated access from an idle arbiter, checked cycle by cycle.
    task automatic run_txn(input vec_t v, input string nm);
        cyc;
        if (v.is_data) begin
            bus.dm_req = 1'b1; bus.dm_wr = v.wr; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        @(negedge clk);
        chk({nm, "_stall_req"}, v.is_data ? bus.dm_stall : bus.if_stall, 1);
        chk({nm, "_idle_en"}, bus.mem_en, 0);
        cyc; @(negedge clk);
        chk({nm, "_issue_en"},   bus.mem_en, 1);
        chk({nm, "_issue_addr"}, bus.mem_addr, v.addr);
        chk({nm, "_issue_wr"},   bus.mem_wr, v.exp_wr);
        chk({nm, "_issue_busy"}, bus.busy, 1);
        if (v.is_data && v.wr) chk({nm, "_issue_wdata"}, bus.mem_wdata, v.wdata);
        for (int k = 1; k < v.lat; k++) begin
            cyc; @(negedge clk);
            chk({nm, "_wait_en"},   bus.mem_en, 0);
            chk({nm, "_wait_addr"}, bus.mem_addr, v.addr);
            chk({nm, "_wait_wr"},   bus.mem_wr, v.exp_wr);
            chk({nm, "_wait_stall"}, v.is_data ? bus.dm_stall : bus.if_stall, 1);
            if (v.is_data && v.wr) chk({nm, "_wait_wdata"}, bus.mem_wdata, v.wdata);
        end
        cyc;
        bus.mem_done = 1'b1; bus.mem_rdata = v.rdata;
        @(negedge clk);
        chk({nm, "_memdone_nodone"}, {bus.if_done, bus.dm_done}, 0);
        cyc;
        bus.mem_done = 1'b0; bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk({nm, "_done"},  v.is_data ? bus.dm_done : bus.if_done, 1);
        chk({nm, "_other_done"}, v.is_data ? bus.if_done : bus.dm_done, 0);
        chk({nm, "_out"},   v.is_data ? bus.dm_rdata : bus.if_instr, v.exp_out);
        chk({nm, "_stall_done"}, v.is_data ? bus.dm_stall : bus.if_stall, 0);
        cyc;
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        @(negedge clk);
        chk({nm, "_pulse_once"}, v.is_data ? bus.dm_done : bus.if_done, 0);
        chk({nm, "_hold"}, v.is_data ? bus.dm_rdata : bus.if_instr, v.exp_out);
        chk({nm, "_no_reissue"}, {bus.busy, bus.mem_en}, 0);
        if (v.is_data) exp_dm_rdata = v.exp_out;
        else           exp_if_instr = v.exp_out;
    endtask

    // Bounded wait for mem_en; answer one cycle later; return at negedge of done cycle.
    task automatic serve(input logic [15:0] exp_addr, input logic [15:0] rdata, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_en"},   bus.mem_en, 1);
        chk({nm, "_addr"}, bus.mem_addr, exp_addr);
        cyc;
        bus.mem_done = 1'b1; bus.mem_rdata = rdata;
        cyc;
        bus.mem_done = 1'b0; bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        exp_if_instr = '0;
        exp_dm_rdata = '0;

        //          is_data wr  addr      wdata     rdata     lat exp_wr exp_out
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 1, 1'b0, 16'hA5C3};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 16'hBEEF, 5, 1'b1, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5A5A, 2, 1'b0, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0F0F, 3, 1'b0, 16'h0F0F};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1, 1'b0, 16'hFFFF};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h8001, 16'h0000, 2, 1'b1, 16'hFFFF};

        do_reset("init");
        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Contention straight after reset: data first in both arbitration modes.
        do_reset("cont");
        cyc;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0300;
        bus.if_req = 1'b1; bus.if_addr = 16'h0400;
        @(negedge clk);
        chk("cont_stalls", {bus.if_stall, bus.dm_stall}, 2'b11);
        cyc; @(negedge clk);
        chk("cont_first_en",   bus.mem_en, 1);
        chk("cont_first_addr", bus.mem_addr, 16'h0300);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'h1111;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0; bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("cont_dm_done",   bus.dm_done, 1);
        chk("cont_dm_rdata",  bus.dm_rdata, 16'h1111);
        chk("cont_if_stall",  bus.if_stall, 1);
        chk("cont_doneq_en",  bus.mem_en, 0);
        cyc; bus.dm_req = 1'b0;
        @(negedge clk);
        chk("cont_fetch_en",   bus.mem_en, 1);
        chk("cont_fetch_addr", bus.mem_addr, 16'h0400);
        chk("cont_dm_once",    bus.dm_done, 0);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'h2222;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0; bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("cont_if_done",  bus.if_done, 1);
        chk("cont_if_instr", bus.if_instr, 16'h2222);
        cyc; bus.if_req = 1'b0;
        @(negedge clk);
        chk("cont_quiet", {bus.busy, bus.mem_en}, 0);
        exp_dm_rdata = 16'h1111;
        exp_if_instr = 16'h2222;

        // Data last granted, then fresh contention: round-robin favours fetch.
        v_tmp = '{1'b1, 1'b0, 16'h0800, 16'h0000, 16'h4444, 1, 1'b0, 16'h4444};
        run_txn(v_tmp, "pre_rr");
`ifdef MEM_ARB_RR_EN
        first_is_data = 1'b0;
`else
        first_is_data = 1'b1;
`endif
        cyc;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0500;
        bus.if_req = 1'b1; bus.if_addr = 16'h0600;
        if (first_is_data) begin
            serve(16'h0500, 16'h5555, "arb1");
            chk("arb1_dm_done", bus.dm_done, 1);
            cyc; bus.dm_req = 1'b0;
            serve(16'h0600, 16'h6666, "arb2");
            chk("arb2_if_done", bus.if_done, 1);
            cyc; bus.if_req = 1'b0;
        end else begin
            serve(16'h0600, 16'h6666, "arb1");
            chk("arb1_if_done", bus.if_done, 1);
            cyc; bus.if_req = 1'b0;
            serve(16'h0500, 16'h5555, "arb2");
            chk("arb2_dm_done", bus.dm_done, 1);
            cyc; bus.dm_req = 1'b0;
        end
        @(negedge clk);
        chk("arb_if_instr", bus.if_instr, 16'h6666);
        chk("arb_dm_rdata", bus.dm_rdata, 16'h5555);
        exp_if_instr = 16'h6666;
        exp_dm_rdata = 16'h5555;

        // Flush during fetch WAIT: access completes silently.
        cyc; bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        @(negedge clk);
        cyc; @(negedge clk);
        chk("fl_issue_addr", bus.mem_addr, 16'h0020);
        cyc; bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        cyc; bus.if_flush = 1'b0;
        @(negedge clk);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0;
        @(negedge clk);
        chk("fl_no_done",  bus.if_done, 0);
        chk("fl_instr",    bus.if_instr, exp_if_instr);
        chk("fl_idle",     bus.busy, 0);
        v_tmp = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0BEE, 1, 1'b0, 16'h0BEE};
        run_txn(v_tmp, "after_flush");

        // Flush in the same cycle as mem_done.
        cyc; bus.if_req = 1'b1; bus.if_addr = 16'h0050;
        @(negedge clk);
        cyc; @(negedge clk);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'h3333; bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0; bus.if_flush = 1'b0;
        @(negedge clk);
        chk("flc_no_done", bus.if_done, 0);
        chk("flc_instr",   bus.if_instr, exp_if_instr);

        // Flush in the done-pulse cycle masks only the pulse.
        cyc; bus.if_req = 1'b1; bus.if_addr = 16'h0060;
        @(negedge clk);
        cyc; @(negedge clk);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0; bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        chk("fld_masked", bus.if_done, 0);
        chk("fld_instr",  bus.if_instr, 16'h7777);
        chk("fld_stall",  bus.if_stall, 0);
        cyc; bus.if_flush = 1'b0;
        @(negedge clk);
        chk("fld_after", bus.if_done, 0);

        // Reset during WAIT, then a late mem_done.
        cyc; bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0700; bus.dm_wdata = 16'h9999;
        @(negedge clk);
        cyc; @(negedge clk);
        cyc; @(negedge clk);
        chk("rw_wait_wr", bus.mem_wr, 1);
        cyc; rst = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        chk("rw_busy",  bus.busy, 0);
        chk("rw_cmd",   {bus.mem_en, bus.mem_wr}, 0);
        chk("rw_addr",  bus.mem_addr, 0);
        chk("rw_wdata", bus.mem_wdata, 0);
        chk("rw_outs",  {bus.if_instr, bus.dm_rdata}, 0);
        cyc; rst = 1'b1;
        @(negedge clk);
        cyc; bus.mem_done = 1'b1; bus.mem_rdata = 16'hABCD;
        @(negedge clk);
        cyc; bus.mem_done = 1'b0;
        @(negedge clk);
        chk("rw_late_done", {bus.if_done, bus.dm_done}, 0);
        chk("rw_late_data", bus.dm_rdata, 0);
        chk("rw_late_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
